// File: rtl/rx_det_pkg.sv
// Shared types and helpers for the multi-lane receiver-detect model.
package rx_det_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCharge = 2'd1,
    StDone   = 2'd2
  } lane_state_e;

  // Detect latency of lane idx: base plus a per-lane skew.
  function automatic int unsigned lane_delay(input int unsigned base,
                                             input int unsigned skew,
                                             input int unsigned idx);
    return base + idx * skew;
  endfunction

  // Number of set bits in a vector of up to 16 lanes.
  function automatic logic [4:0] popcount(input logic [15:0] vec);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rx_det_lane.sv
// One receiver-detect lane: IDLE/CHARGE/DONE FSM with a latency down-counter
// and a sticky detect result.
module rx_det_lane
  import rx_det_pkg::*;
#(
  parameter int unsigned DELAY = 500,
  parameter int unsigned CNT_W = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic present_i,
  output logic ack_o,
  output logic vld_o,
  output logic busy_o,
  output logic done_o
);

  localparam logic [CNT_W-1:0] LoadVal = CNT_W'(DELAY - 1);

  lane_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;

  // Next-state: counter runs only in CHARGE; result is captured on the final
  // CHARGE edge and otherwise held until the next detect starts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          state_d = StCharge;
          cnt_d   = LoadVal;
          vld_d   = 1'b0;
        end
      end
      StCharge: begin
        if (!req_i) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StDone;
          vld_d   = present_i;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (!req_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counter and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    ack_o  = (state_q == StDone);
    done_o = (state_q == StDone);
    busy_o = (state_q == StCharge);
    vld_o  = vld_q;
  end

endmodule

// File: rtl/rx_det_array.sv
// N-lane receiver-detect array: independent per-lane FSMs plus registered
// aggregate status (all-done flag and detected-lane count).
module rx_det_array
  import rx_det_pkg::*;
#(
  parameter int unsigned LANES        = 4,
  parameter int unsigned DELAY_CYCLES = 500,
  parameter int unsigned LANE_SKEW    = 0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANES-1:0]             rx_present,
  input  logic [LANES-1:0]             rx_det_req,
  output logic [LANES-1:0]             rx_det_ack,
  output logic [LANES-1:0]             rx_det_vld,
  output logic [LANES-1:0]             lane_busy,
  output logic                         det_done_all,
  output logic [$clog2(LANES+1)-1:0]   det_count
);

  localparam int unsigned CountW   = $clog2(LANES + 1);
  localparam int unsigned MaxDelay = lane_delay(DELAY_CYCLES, LANE_SKEW, LANES - 1);

  // Reject configurations the counters or aggregation cannot represent.
  if (LANES < 1 || LANES > 16) begin : gen_lanes_check
    $error("rx_det_array: LANES must be in 1..16");
  end
  if (DELAY_CYCLES < 1) begin : gen_delay_check
    $error("rx_det_array: DELAY_CYCLES must be >= 1");
  end
  if (64'(MaxDelay) >= (64'd1 << CNT_W)) begin : gen_cnt_w_check
    $error("rx_det_array: CNT_W too narrow for the longest lane delay");
  end

  logic [LANES-1:0] lane_done;

  for (genvar i = 0; i < LANES; i++) begin : gen_lane
    rx_det_lane #(
      .DELAY (lane_delay(DELAY_CYCLES, LANE_SKEW, i)),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk_i     (clk),
      .rst_ni    (rst),
      .req_i     (rx_det_req[i]),
      .present_i (rx_present[i]),
      .ack_o     (rx_det_ack[i]),
      .vld_o     (rx_det_vld[i]),
      .busy_o    (lane_busy[i]),
      .done_o    (lane_done[i])
    );
  end

  logic              done_all_q, done_all_d;
  logic [CountW-1:0] count_q, count_d;

  // Aggregate status computed from the current lane outputs.
  always_comb begin
    done_all_d = &lane_done;
    count_d    = CountW'(popcount(16'(rx_det_vld)));
  end

  // Aggregation registers (one cycle behind the lanes).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_all_q <= 1'b0;
      count_q    <= '0;
    end else begin
      done_all_q <= done_all_d;
      count_q    <= count_d;
    end
  end

  // Drive aggregate outputs.
  always_comb begin
    det_done_all = done_all_q;
    det_count    = count_q;
  end

endmodule

// File: tb/tb_rx_det_array.sv
// Directed self-checking bench for rx_det_array: one instance without lane
// skew and one with LANE_SKEW=3, both with an 8-cycle base delay.
module tb_rx_det_array;

  localparam int unsigned Lanes = 4;

  logic             clk;
  logic             rst;
  logic [Lanes-1:0] present0, req0, ack0, vld0, busy0;
  logic [Lanes-1:0] present1, req1, ack1, vld1, busy1;
  logic             done0, done1;
  logic [2:0]       cnt0, cnt1;

  int n_vec;
  int n_err;

  rx_det_array #(
    .LANES        (Lanes),
    .DELAY_CYCLES (8),
    .LANE_SKEW    (0),
    .CNT_W        (16)
  ) u_dut0 (
    .clk          (clk),
    .rst          (rst),
    .rx_present   (present0),
    .rx_det_req   (req0),
    .rx_det_ack   (ack0),
    .rx_det_vld   (vld0),
    .lane_busy    (busy0),
    .det_done_all (done0),
    .det_count    (cnt0)
  );

  rx_det_array #(
    .LANES        (Lanes),
    .DELAY_CYCLES (8),
    .LANE_SKEW    (3),
    .CNT_W        (16)
  ) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .rx_present   (present1),
    .rx_det_req   (req1),
    .rx_det_ack   (ack1),
    .rx_det_vld   (vld1),
    .lane_busy    (busy1),
    .det_done_all (done1),
    .det_count    (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then park on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b0;
    req0     = '0;
    req1     = '0;
    present0 = '0;
    present1 = '0;

    // Reset state.
    step(2);
    check_eq("rst_ack", 32'(ack0), 32'h0);
    check_eq("rst_vld", 32'(vld0), 32'h0);
    check_eq("rst_busy", 32'(busy0), 32'h0);
    check_eq("rst_done_all", 32'(done0), 32'h0);
    check_eq("rst_count", 32'(cnt0), 32'h0);
    rst = 1'b1;
    step(1);

    // All lanes present, simultaneous request: ack/vld at edge 8.
    present0 = 4'b1111;
    req0     = 4'b1111;
    step(8);
    check_eq("t1_ack_e7", 32'(ack0), 32'h0);
    check_eq("t1_busy_e7", 32'(busy0), 32'hF);
    step(1);
    check_eq("t1_ack_e8", 32'(ack0), 32'hF);
    check_eq("t1_vld_e8", 32'(vld0), 32'hF);
    check_eq("t1_done_e8", 32'(done0), 32'h0);
    step(1);
    check_eq("t1_done_e9", 32'(done0), 32'h1);
    check_eq("t1_count_e9", 32'(cnt0), 32'h4);
    req0 = '0;
    step(1);
    check_eq("t1_ack_fall", 32'(ack0), 32'h0);
    check_eq("t1_vld_sticky", 32'(vld0), 32'hF);
    step(1);
    check_eq("t1_done_fall", 32'(done0), 32'h0);
    check_eq("t1_count_hold", 32'(cnt0), 32'h4);

    // Partial presence.
    present0 = 4'b0101;
    req0     = 4'b1111;
    step(1);
    check_eq("t2_vld_clr", 32'(vld0), 32'h0);
    step(8);
    check_eq("t2_ack_e8", 32'(ack0), 32'hF);
    check_eq("t2_vld_e8", 32'(vld0), 32'h5);
    step(1);
    check_eq("t2_count_e9", 32'(cnt0), 32'h2);
    check_eq("t2_done_e9", 32'(done0), 32'h1);
    req0 = '0;
    step(2);

    // Skewed lanes: acks at edges 8, 11, 14, 17; all-done at 18.
    present1 = 4'b1111;
    req1     = 4'b1111;
    step(9);
    check_eq("t3_ack_e8", 32'(ack1), 32'h1);
    step(3);
    check_eq("t3_ack_e11", 32'(ack1), 32'h3);
    step(2);
    check_eq("t3_ack_e13", 32'(ack1), 32'h3);
    step(1);
    check_eq("t3_ack_e14", 32'(ack1), 32'h7);
    step(3);
    check_eq("t3_ack_e17", 32'(ack1), 32'hF);
    check_eq("t3_done_e17", 32'(done1), 32'h0);
    step(1);
    check_eq("t3_done_e18", 32'(done1), 32'h1);
    req1 = '0;
    step(2);

    // Lane 2 request withdrawn after 5 cycles: abort, no ack.
    present0 = 4'b1111;
    req0     = 4'b0100;
    step(1);
    check_eq("t4_busy_e0", 32'(busy0), 32'h4);
    step(4);
    check_eq("t4_busy_e4", 32'(busy0), 32'h4);
    req0 = '0;
    step(1);
    check_eq("t4_busy_e5", 32'(busy0), 32'h0);
    step(10);
    check_eq("t4_ack_none", 32'(ack0), 32'h0);
    check_eq("t4_vld", 32'(vld0), 32'h1);

    // Reset in the middle of CHARGE with req held.
    present0 = 4'b1111;
    req0     = 4'b1111;
    step(5);
    rst = 1'b0;
    #2;
    check_eq("t5_busy_async", 32'(busy0), 32'h0);
    check_eq("t5_vld_async", 32'(vld0), 32'h0);
    check_eq("t5_count_async", 32'(cnt0), 32'h0);
    step(2);
    check_eq("t5_ack_inrst", 32'(ack0), 32'h0);
    check_eq("t5_busy_inrst", 32'(busy0), 32'h0);
    rst = 1'b1;
    step(8);
    check_eq("t5_ack_r7", 32'(ack0), 32'h0);
    check_eq("t5_busy_r7", 32'(busy0), 32'hF);
    step(1);
    check_eq("t5_ack_r8", 32'(ack0), 32'hF);
    req0 = '0;
    step(2);

    // Lane 0 back-to-back handshake with presence toggled 1 -> 0.
    present0 = 4'b0001;
    req0     = 4'b0001;
    step(9);
    check_eq("t6_ack1", 32'(ack0), 32'h1);
    check_eq("t6_vld1", 32'(vld0[0]), 32'h1);
    req0     = '0;
    present0 = '0;
    step(1);
    check_eq("t6_ack_fall", 32'(ack0), 32'h0);
    check_eq("t6_vld_held", 32'(vld0[0]), 32'h1);
    req0 = 4'b0001;
    step(1);
    check_eq("t6_busy_restart", 32'(busy0), 32'h1);
    check_eq("t6_vld_clr", 32'(vld0[0]), 32'h0);
    step(7);
    check_eq("t6_ack_e7", 32'(ack0), 32'h0);
    step(1);
    check_eq("t6_ack2", 32'(ack0), 32'h1);
    check_eq("t6_vld2", 32'(vld0), 32'hE);
    step(1);
    check_eq("t6_count", 32'(cnt0), 32'h3);
    req0 = '0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rx_det_array.md
Name: rx_det_array

Overview:
- Parametrised N-lane receiver-detect model driven by LTSSM Detect.Active; the successor to the single-lane rx_det_circuit.
- Each lane has its own FSM. A per-lane four-phase req/ack handshake replaces the implicit one-shot behaviour.
- Adds per-lane detect latency skew, abort on req withdrawal, a sticky result, and aggregate status (all-lanes-done flag, detected-lane count).
- Sits between the LTSSM lane_rx_det_seq_req/ack/rx_det ports and the bench's per-lane presence stimulus.

Parameters:
- LANES, 4, number of lanes (1..16).
- DELAY_CYCLES, 500, base detect latency in clk cycles (>=1).
- LANE_SKEW, 0, extra cycles per lane index: D_i = DELAY_CYCLES + i*LANE_SKEW.
- CNT_W, 16, down-counter width; must satisfy max D_i < 2^CNT_W (elaboration-time check).

Ports:
- clk  input  1  system clock (1 GHz in bench)
- rst  input  1  asynchronous, active-low reset
- rx_present  input  LANES  per-lane far-end termination present (level)
- rx_det_req  input  LANES  per-lane detect request from LTSSM
- rx_det_ack  output  LANES  per-lane detect complete
- rx_det_vld  output  LANES  per-lane detect result (1 = receiver found)
- lane_busy  output  LANES  lane in CHARGE state
- det_done_all  output  1  every lane simultaneously in DONE
- det_count  output  $clog2(LANES+1)  number of set bits in rx_det_vld

Behaviour:
- Reset (rst=0, asynchronous) applies to every lane:
  - FSM goes to IDLE; counter = 0.
  - rx_det_ack = 0, rx_det_vld = 0, lane_busy = 0, det_done_all = 0, det_count = 0.
- Per-lane FSM, all lanes independent:
  - IDLE: if req=1 at edge k → CHARGE; counter loads D_i-1; vld clears to 0 at edge k.
  - CHARGE: lane_busy=1, ack=0.
    - If req=0 → IDLE (abort); no ack; vld stays 0.
    - Else if counter=0 → DONE; vld <= rx_present[i] sampled at this same edge.
    - Else counter decrements.
  - DONE: ack=1.
    - req=0 → IDLE; ack falls on that edge.
    - Otherwise hold DONE.
- Latency: ack and vld rise at edge k+D_i, where k is the edge that first samples req=1.
- rx_det_vld is sticky. It is held through DONE and IDLE and cleared only on the next IDLE→CHARGE transition.
- rx_present changes during CHARGE are ignored; only the value at the final CHARGE edge matters.
- Back-to-back requests: req re-asserted in the cycle after ack falls is legal. IDLE sees req=1 and starts a new CHARGE; minimum IDLE dwell is 1 cycle.
- A req pulse shorter than D_i aborts; no ack is ever produced for it.
- det_done_all: registered AND of (state==DONE) over all lanes; one cycle after the last lane enters DONE.
- det_count: registered popcount of rx_det_vld; lags rx_det_vld by 1 cycle; width handles LANES=16 → 5 bits.
- Reset mid-CHARGE/DONE: immediate return to IDLE. A req still high after reset release starts a fresh full D_i count.
- With LANE_SKEW=0 and simultaneous reqs, all lanes ack on the same edge.

Decomposition:
- Package rx_det_pkg:
  - lane state enum {IDLE=2'd0, CHARGE=2'd1, DONE=2'd2};
  - function for lane delay D_i;
  - popcount function.
- Sub-module rx_det_lane: one FSM plus counter, parameters DELAY and CNT_W, instantiated LANES times via generate.
- The top level holds only the aggregation registers.

Test Plan:
- LANES=4, DELAY_CYCLES=8, LANE_SKEW=0, present=4'b1111, req=4'b1111 at edge 0 → ack=4'b1111 and vld=4'b1111 at edge 8; det_done_all=1 at edge 9; det_count=4 at edge 9.
- Same parameters, present=4'b0101 → ack=4'b1111 at edge 8; vld=4'b0101; det_count=2.
- LANE_SKEW=3, all req at edge 0 → acks at edges 8, 11, 14, 17 for lanes 0..3; det_done_all rises at edge 18.
- Lane 2 req high for 5 cycles then low → no ack on lane 2; lane_busy[2] high for edges 0..4 (5 cycles); vld[2]=0.
- rst asserted at edge 4 of CHARGE, released with req held → all outputs 0 during reset; ack at release_edge+8.
- Lane 0 full handshake, req dropped, re-raised next cycle with present toggled 1→0 → vld[0]=1 after the first ack, clears when the second CHARGE starts, ack again 8 cycles later with vld[0]=0.
